pwm_sample_sequencer: RTL and testbench

PWM_SAMPLE_SEQUENCER -- requirements
Module: pwm_sample_sequencer

---
 rtl/pwm_seq_pkg.sv | 21 ++
 rtl/sample_fifo.sv | 60 ++++++
 rtl/pwm_sample_sequencer.sv | 125 ++++++++++++
 tb/tb_pwm_sample_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_seq_pkg.sv
// ---------------------------------------------------------------------------
// pwm_seq_pkg : shared types and constants for the PWM sample sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pwm_seq_pkg;

  localparam int SAMPLE_W       = 12;
  localparam int DEFAULT_PERIOD = 4095;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 12'h800;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PLAY     = 2'd1,
    ST_UNDERRUN = 2'd2
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// ---------------------------------------------------------------------------
// sample_fifo : synchronous FIFO with occupancy output (DEPTH power of two, >=2)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     not_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign not_full = (r_level < LW'(DEPTH));
  assign w_push   = push && not_full;
  assign w_pop    = pop && (r_level != '0);
  assign pop_data = r_mem[r_rd_ptr];
  assign level    = r_level;

  // Storage needs no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/pwm_sample_sequencer.sv
// ---------------------------------------------------------------------------
// pwm_sample_sequencer : frame counter + playback FSM feeding one sample per PWM frame
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pwm_sample_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int PERIOD  = DEFAULT_PERIOD,
  parameter int DEPTH   = 4,
  parameter int PREFILL = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic [SAMPLE_W-1:0]      in_sample,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     clr_underrun,
  output logic [SAMPLE_W-1:0]      sample_out,
  output logic                     frame_strobe,
  output logic                     underrun,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               state
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int LW = $clog2(DEPTH) + 1;

  logic [CW-1:0]       r_cnt;
  logic                w_boundary;
  logic                r_strobe;
  seq_state_e          r_state, w_state_nxt;
  logic [SAMPLE_W-1:0] r_sample, w_sample_nxt;
  logic                r_underrun, w_underrun_nxt;
  logic                w_pop;
  logic                w_push;
  logic [SAMPLE_W-1:0] w_head;
  logic [LW-1:0]       w_level;

  assign w_boundary = enable && (r_cnt == CW'(PERIOD - 1));
  assign w_push     = in_valid && in_ready;

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (in_sample),
    .pop       (w_pop),
    .pop_data  (w_head),
    .level     (w_level),
    .not_full  (in_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_boundary;
      if (!enable || w_boundary) r_cnt <= '0;
      else                       r_cnt <= r_cnt + CW'(1);
    end
  end

  // Decisions use the registered level, so a same-cycle push only counts next frame.
  always_comb begin
    w_state_nxt    = r_state;
    w_sample_nxt   = r_sample;
    w_pop          = 1'b0;
    w_underrun_nxt = r_underrun && !clr_underrun;
    if (!enable) begin
      w_state_nxt  = ST_IDLE;
      w_sample_nxt = MIDSCALE;
    end else if (w_boundary) begin
      case (r_state)
        ST_IDLE, ST_UNDERRUN: begin
          if (w_level >= LW'(PREFILL)) begin
            w_pop        = 1'b1;
            w_sample_nxt = w_head;
            w_state_nxt  = ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (w_level != '0) begin
            w_pop        = 1'b1;
            w_sample_nxt = w_head;
          end else begin
            w_underrun_nxt = 1'b1;
            w_state_nxt    = ST_UNDERRUN;
          end
        end
        default: begin
          w_state_nxt  = ST_IDLE;
          w_sample_nxt = MIDSCALE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_sample   <= MIDSCALE;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sample   <= w_sample_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  assign sample_out   = r_sample;
  assign frame_strobe = r_strobe;
  assign underrun     = r_underrun;
  assign level        = w_level;
  assign state        = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pwm_sample_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pwm_sample_sequencer : directed self-checking bench (PERIOD=16, DEPTH=4, PREFILL=2)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pwm_sample_sequencer;

  localparam int PERIOD  = 16;
  localparam int DEPTH   = 4;
  localparam int PREFILL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [11:0] in_sample;
  logic        in_valid;
  logic        in_ready;
  logic        clr_underrun;
  logic [11:0] sample_out;
  logic        frame_strobe;
  logic        underrun;
  logic [2:0]  level;
  logic [1:0]  state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pwm_sample_sequencer #(
    .PERIOD  (PERIOD),
    .DEPTH   (DEPTH),
    .PREFILL (PREFILL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .in_sample    (in_sample),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .clr_underrun (clr_underrun),
    .sample_out   (sample_out),
    .frame_strobe (frame_strobe),
    .underrun     (underrun),
    .level        (level),
    .state        (state)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] d);
    in_sample = d;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  // Ticks until the frame strobe is seen; n returns the number of edges taken.
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_strobe && n < 64);
    if (!frame_strobe) check("strobe_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    int cnt;
    rst          = 1'b1;
    enable       = 1'b0;
    in_valid     = 1'b0;
    in_sample    = '0;
    clr_underrun = 1'b0;

    #2;
    check("rst_sample",   sample_out,   32'h800);
    check("rst_level",    level,        32'd0);
    check("rst_state",    state,        32'd0);
    check("rst_strobe",   frame_strobe, 32'd0);
    check("rst_underrun", underrun,     32'd0);
    check("rst_ready",    in_ready,     32'd1);

    tick(); tick();
    rst    = 1'b0;
    enable = 1'b1;

    // Idle frames with an empty FIFO
    wait_strobe(n);
    check("idle_period1", n, 32'd16);
    check("idle_sample1", sample_out, 32'h800);
    check("idle_state1",  state, 32'd0);
    tick();
    check("strobe_width", frame_strobe, 32'd0);
    wait_strobe(n);
    check("idle_period2", n, 32'd15);
    check("idle_sample2", sample_out, 32'h800);

    // Prefill two samples, then play them out
    push(12'h100);
    push(12'h200);
    check("prefill_level", level, 32'd2);
    wait_strobe(n);
    check("play1_wait",   n, 32'd14);
    check("play1_sample", sample_out, 32'h100);
    check("play1_state",  state, 32'd1);
    check("play1_level",  level, 32'd1);
    wait_strobe(n);
    check("play2_sample", sample_out, 32'h200);
    check("play2_level",  level, 32'd0);

    // Starve the FIFO
    wait_strobe(n);
    check("ur_sample",   sample_out, 32'h200);
    check("ur_flag",     underrun, 32'd1);
    check("ur_state",    state, 32'd2);
    push(12'h300);
    wait_strobe(n);
    check("ur1_state",   state, 32'd2);
    check("ur1_sample",  sample_out, 32'h200);
    check("ur1_level",   level, 32'd1);
    push(12'h400);
    wait_strobe(n);
    check("resume_state",  state, 32'd1);
    check("resume_sample", sample_out, 32'h300);

    // Clear alone, then clear coinciding with a fresh underrun set
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    check("clr_alone", underrun, 32'd0);
    wait_strobe(n);
    check("play4_sample", sample_out, 32'h400);
    check("play4_level",  level, 32'd0);
    repeat (PERIOD - 1) tick();
    clr_underrun = 1'b1;
    tick();
    clr_underrun = 1'b0;
    check("set_wins_flag",  underrun, 32'd1);
    check("set_wins_state", state, 32'd2);
    check("set_wins_strb",  frame_strobe, 32'd1);

    // Fill to DEPTH, attempt overflow
    push(12'hA01);
    push(12'hA02);
    push(12'hA03);
    push(12'hA04);
    check("full_level", level, 32'd4);
    check("full_ready", in_ready, 32'd0);
    in_sample = 12'hEEE;
    in_valid  = 1'b1;
    tick(); tick();
    in_valid  = 1'b0;
    check("ovf_level", level, 32'd4);
    wait_strobe(n);
    check("full_pop_sample", sample_out, 32'hA01);
    check("full_pop_state",  state, 32'd1);
    check("full_pop_level",  level, 32'd3);

    // Push on the boundary cycle while a pop happens at level 3
    repeat (PERIOD - 1) tick();
    in_sample = 12'h555;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    check("pushpop_level",  level, 32'd3);
    check("pushpop_sample", sample_out, 32'hA02);

    // Asynchronous reset mid-PLAY
    repeat (3) tick();
    rst = 1'b1;
    #2;
    check("arst_sample",   sample_out, 32'h800);
    check("arst_level",    level, 32'd0);
    check("arst_state",    state, 32'd0);
    check("arst_underrun", underrun, 32'd0);
    check("arst_ready",    in_ready, 32'd1);
    tick();
    rst = 1'b0;

    // Frame realignment after reset release; the 555 entry must be gone
    push(12'h111);
    push(12'h222);
    wait_strobe(n);
    check("realign_wait",   n, 32'd14);
    check("realign_sample", sample_out, 32'h111);
    check("realign_level",  level, 32'd1);

    // Disable mid-frame
    repeat (5) tick();
    enable = 1'b0;
    tick();
    check("dis_sample", sample_out, 32'h800);
    check("dis_state",  state, 32'd0);
    check("dis_level",  level, 32'd1);
    push(12'h333);
    check("dis_push_level", level, 32'd2);
    cnt = 0;
    repeat (20) begin
      tick();
      if (frame_strobe) cnt++;
    end
    check("dis_no_strobe", cnt, 32'd0);
    check("dis_hold_sample", sample_out, 32'h800);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
